dmem_block_mover: RTL and testbench
===================================

Name: dmem_block_mover

Overview:
- Bus initiator for the 64x16 data memory. Drives its mem_read/mem_write/address/write_data pins and consumes its registered read_data.
- Performs block copy (src→dst) and block fill (constant→dst) of up to 64 words on a single start pulse.
- Used by the CPU control path for memory init and stack/array moves.
- Owns the memory port while busy; the CPU must not drive the memory while busy=1.

Parameters:
- ADDR_W, 16, address width of the memory interface.
- DATA_W, 16, data word width.
- LEN_W, 7, width of length field (0..64 words).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when idle (busy=0).
- mode  input  1  0 = copy, 1 = fill.
- src_addr  input  ADDR_W  first source word address (copy only).
- dst_addr  input  ADDR_W  first destination word address.
- length  input  LEN_W  word count; values above 64 are clamped to 64.
- fill_data  input  DATA_W  fill value (fill only).
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- mem_read  output  1  to memory mem_read.
- mem_write  output  1  to memory mem_write.
- address  output  ADDR_W  to memory address.
- write_data  output  DATA_W  to memory write_data.
- read_data  input  DATA_W  from memory; valid in the cycle after an edge where mem_read=1.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy=0, done=0, mem_read=0, mem_write=0, address=0.
  - Internal src/dst/remaining/fill registers cleared.
  - Reset mid-operation abandons the transfer: any pending write is never issued, and no done pulse is produced.
- States: IDLE, RD, WR.
  - busy=1 in RD and WR.
  - mem_read=1 only in RD; mem_write=1 only in WR.
  - Control outputs are decoded from registered state and registered address.
- Start acceptance, at edge E0 with start=1 in IDLE:
  - Latch src, dst, clamped length, mode and fill_data.
  - start while busy is ignored, and input operands are not re-sampled.
  - start is accepted in the same cycle that done=1.
- length=0: no memory access. done=1 for the cycle after E0; busy stays 0; state stays IDLE.
- Copy, N words:
  - After E0: RD, address=src.
  - At the next edge the memory captures mem[src]. Move to WR, address=dst, write_data=read_data (combinational pass-through of the read_data input).
  - At the following edge the word is written. remaining decrements; src and dst increment.
  - If remaining>0, return to RD; otherwise go to IDLE with done=1.
  - 2 cycles per word. done is high after edge E(2N).
- Fill, N words:
  - Go directly to WR with address=dst and write_data=latched fill_data.
  - One write per edge, dst+1 each edge.
  - done is high after edge E(N).
- write_data in IDLE and RD is the latched fill value or 0; it is don't-care for verification when mem_write=0.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF+1 = 0x0000. The memory decodes only the low 6 bits, so a 64-word block wraps inside the array.
- Overlapping regions are copied strictly forward, word by word.
  - dst = src+1 replicates mem[src] across the block. This is defined behaviour, not an error.
- done is exactly one cycle wide and coincides with the first idle cycle. busy falls on the same edge that done rises.
- mem_read and mem_write are never high in the same cycle.

Test Plan:
- Fill: start, mode=1, dst=0x0010, length=4, fill=0xA5A5 → mem_write high on 4 consecutive cycles with address 0x10..0x13; done pulse after 4th write edge; mem[16..19]=0xA5A5.
- Copy: preload mem[0..2]={0x1111,0x2222,0x3333}; start mode=0, src=0, dst=0x20, length=3 → alternating RD/WR for 6 cycles; mem[32..34] match the source; done after edge 6; busy 6 cycles.
- length=0 and length=100: length=0 → done next cycle, no mem_read/mem_write ever asserted. length=100 → exactly 64 writes (clamped).
- Wrap and overlap:
  - Fill dst=0xFFFE, length=3 → addresses 0xFFFE, 0xFFFF, 0x0000.
  - Copy src=5, dst=6, length=3 with mem[5]=0x0BEE → mem[6..8]=0x0BEE.
- start while busy: second start mid-copy with different operands → ignored, original transfer completes unchanged, single done pulse.
- Async reset mid-copy: assert rst between RD and WR of word 2 → outputs 0 immediately (no clock), no write of word 2, no done. A new start after deassert runs normally.

Source files
------------

// File: rtl/dmem_block_mover_if.sv
// Command and memory-bus signals for the data-memory block mover.
// The master modport is the mover; the slave modport is the CPU/memory side.
interface dmem_block_mover_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 7
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] fill_data;
    logic              busy;
    logic              done;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (
        input  start, mode, src_addr, dst_addr, length, fill_data, read_data,
        output busy, done, mem_read, mem_write, address, write_data
    );

    modport slave (
        output start, mode, src_addr, dst_addr, length, fill_data, read_data,
        input  busy, done, mem_read, mem_write, address, write_data
    );
endinterface

// File: rtl/dmem_block_mover.sv
// Block copy / block fill engine that owns the 64x16 data-memory port while busy.
// Copy costs two cycles per word (read then write); fill writes one word per cycle.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after a transfer
// RD    | copy only: mem_read at source address
// WR    | mem_write at destination; data is read_data (copy) or fill value
module dmem_block_mover #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 7
) (
    input  logic                clk,
    input  logic                rst,
    dmem_block_mover_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(64);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_rem;
    logic [DATA_W-1:0] r_fill;
    logic              r_mode;
    logic              r_done;
    logic [LEN_W-1:0]  w_len_clamp;
    logic              w_accept;
    logic              w_last;

    assign w_len_clamp = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
    assign w_accept    = (r_state == S_IDLE) && bus.start;
    assign w_last      = (r_rem == LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_len_clamp != '0))
                    w_next = bus.mode ? S_WR : S_RD;
            end
            S_RD:   w_next = S_WR;
            S_WR: begin
                if (w_last)       w_next = S_IDLE;
                else if (!r_mode) w_next = S_RD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_rem  <= '0;
            r_fill <= '0;
            r_mode <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (w_accept && (w_len_clamp == '0)) || ((r_state == S_WR) && w_last);
            if (w_accept) begin
                r_src  <= bus.src_addr;
                r_dst  <= bus.dst_addr;
                r_rem  <= w_len_clamp;
                r_fill <= bus.fill_data;
                r_mode <= bus.mode;
            end else if (r_state == S_WR) begin
                // Both pointers advance per written word; address math wraps at 2^ADDR_W.
                r_src <= r_src + ADDR_W'(1);
                r_dst <= r_dst + ADDR_W'(1);
                r_rem <= r_rem - LEN_W'(1);
            end
        end
    end

    always_comb begin
        bus.busy       = 1'b0;
        bus.done       = r_done;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.address    = '0;
        bus.write_data = r_fill;
        case (r_state)
            S_RD: begin
                bus.busy     = 1'b1;
                bus.mem_read = 1'b1;
                bus.address  = r_src;
            end
            S_WR: begin
                bus.busy      = 1'b1;
                bus.mem_write = 1'b1;
                bus.address   = r_dst;
                if (!r_mode) bus.write_data = bus.read_data;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dmem_block_mover.sv
// Self-checking bench for dmem_block_mover: 64x16 memory model, bus monitor and
// a word-by-word reference model of copy/fill transfers.
module tb_dmem_block_mover;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_block_mover_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    dmem_block_mover #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory: registered read, low 6 address bits decoded; bench-side load port.
    logic [DW-1:0] mem [64];
    logic          tb_we;
    logic [5:0]    tb_wa;
    logic [DW-1:0] tb_wd;

    always @(posedge clk) begin
        if (bus.mem_read) bus.read_data <= mem[bus.address[5:0]];
        if (bus.mem_write)  mem[bus.address[5:0]] <= bus.write_data;
        else if (tb_we)     mem[tb_wa] <= tb_wd;
    end

    // Bus monitor, sampled mid-cycle.
    logic [AW-1:0] wr_a_q [$];
    logic [DW-1:0] wr_d_q [$];
    logic [AW-1:0] rd_a_q [$];
    int done_total = 0;
    int busy_total = 0;
    int both_total = 0;

    always @(negedge clk) begin
        if (bus.mem_write) begin
            wr_a_q.push_back(bus.address);
            wr_d_q.push_back(bus.write_data);
        end
        if (bus.mem_read) rd_a_q.push_back(bus.address);
        if (bus.done === 1'b1) done_total <= done_total + 1;
        if (bus.busy === 1'b1) busy_total <= busy_total + 1;
        if (bus.mem_read && bus.mem_write) both_total <= both_total + 1;
    end

    // Reference model state
    logic [DW-1:0] ref_mem [64];
    logic [AW-1:0] exp_wa [$];
    logic [DW-1:0] exp_wd [$];
    logic [AW-1:0] exp_ra [$];
    int exp_lat;

    int checks = 0;
    int passes = 0;

    task automatic model_op(input bit m, input logic [15:0] s, input logic [15:0] d,
                            input logic [6:0] l, input logic [15:0] f);
        int n;
        logic [15:0] a, ra, v;
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
        n = (l > 7'd64) ? 64 : int'(l);
        for (int i = 0; i < n; i++) begin
            a = d + 16'(i);
            if (m) v = f;
            else begin
                ra = s + 16'(i);
                exp_ra.push_back(ra);
                v = ref_mem[ra[5:0]];
            end
            ref_mem[a[5:0]] = v;
            exp_wa.push_back(a);
            exp_wd.push_back(v);
        end
        exp_lat = m ? n : 2 * n;
    endtask

    task automatic poke(input int a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = 6'(a); tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Issues one start pulse and waits (bounded) for done; lat = edges after E0.
    task automatic do_op(input bit sync, input bit m, input logic [15:0] s, input logic [15:0] d,
                         input logic [6:0] l, input logic [15:0] f,
                         output int lat, output bit tmo);
        if (sync) @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.src_addr = s; bus.dst_addr = d;
        bus.length = l; bus.fill_data = f;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = -1;
        tmo = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = k;
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1; bus.mode = 1'b1; bus.dst_addr = 16'h0004; bus.length = 7'd5;
        bus.fill_data = 16'h1234; bus.src_addr = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.address} !== 20'h0)
            $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h, expected all 0",
                     bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.address);
        else passes++;
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk); #1;
        checks++;
        if ({bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.address} !== 20'h0)
            $display("FAIL idle_after_reset: got busy=%b done=%b rd=%b wr=%b addr=%h, expected all 0",
                     bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.address);
        else passes++;
        checks++;
        if (busy_total != 0 || done_total != 0)
            $display("FAIL reset_no_activity: got busy_cycles=%0d done_pulses=%0d, expected 0/0",
                     busy_total, done_total);
        else passes++;
    endtask

    task automatic test_transfers();
        bit m; logic [15:0] s, d, f; logic [6:0] l;
        int lat, wb, rb, db, bb, bad;
        bit tmo;
        for (int i = 0; i < 64; i++) poke(i, 16'($urandom));
        poke(0, 16'h1111); poke(1, 16'h2222); poke(2, 16'h3333); poke(5, 16'h0BEE);
        for (int t = 0; t < 20; t++) begin
            case (t)
                0: begin m = 1; s = 16'h0;    d = 16'h0010; l = 7'd4;   f = 16'hA5A5; end
                1: begin m = 0; s = 16'h0;    d = 16'h0020; l = 7'd3;   f = 16'h0;    end
                2: begin m = 0; s = 16'h0005; d = 16'h0006; l = 7'd3;   f = 16'h0;    end
                3: begin m = 0; s = 16'h0009; d = 16'h0030; l = 7'd0;   f = 16'h0;    end
                4: begin m = 1; s = 16'h0;    d = 16'h0100; l = 7'd100; f = 16'h5A5A; end
                5: begin m = 1; s = 16'h0;    d = 16'hFFFE; l = 7'd3;   f = 16'hC3C3; end
                6: begin m = 0; s = 16'hFFF0; d = 16'h0008; l = 7'd100; f = 16'h0;    end
                default: begin
                    m = 1'($urandom_range(0, 1)); s = 16'($urandom); d = 16'($urandom);
                    l = 7'($urandom_range(0, 100)); f = 16'($urandom);
                end
            endcase
            model_op(m, s, d, l, f);
            wb = wr_a_q.size(); rb = rd_a_q.size(); db = done_total; bb = busy_total;
            do_op(1'b1, m, s, d, l, f, lat, tmo);
            repeat (2) @(negedge clk); #1;
            checks++;
            if (tmo) $display("FAIL op%0d_timeout: done never seen, expected within %0d cycles", t, exp_lat + 1);
            else passes++;
            checks++;
            if (lat != exp_lat) $display("FAIL op%0d_latency: got %0d edges, expected %0d", t, lat, exp_lat);
            else passes++;
            checks++;
            if (busy_total - bb != exp_lat)
                $display("FAIL op%0d_busy_cycles: got %0d, expected %0d", t, busy_total - bb, exp_lat);
            else passes++;
            checks++;
            if (done_total - db != 1) $display("FAIL op%0d_done_pulses: got %0d, expected 1", t, done_total - db);
            else passes++;
            checks++;
            if (wr_a_q.size() - wb != exp_wa.size())
                $display("FAIL op%0d_write_count: got %0d, expected %0d", t, wr_a_q.size() - wb, exp_wa.size());
            else begin
                passes++;
                bad = 0;
                for (int i = 0; i < exp_wa.size(); i++)
                    if (wr_a_q[wb + i] !== exp_wa[i] || wr_d_q[wb + i] !== exp_wd[i]) bad++;
                checks++;
                if (bad != 0) $display("FAIL op%0d_write_seq: got %0d wrong writes, expected 0", t, bad);
                else passes++;
            end
            checks++;
            if (rd_a_q.size() - rb != exp_ra.size())
                $display("FAIL op%0d_read_count: got %0d, expected %0d", t, rd_a_q.size() - rb, exp_ra.size());
            else begin
                passes++;
                bad = 0;
                for (int i = 0; i < exp_ra.size(); i++)
                    if (rd_a_q[rb + i] !== exp_ra[i]) bad++;
                checks++;
                if (bad != 0) $display("FAIL op%0d_read_addrs: got %0d wrong reads, expected 0", t, bad);
                else passes++;
            end
            bad = 0;
            for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
            checks++;
            if (bad != 0) $display("FAIL op%0d_mem_image: got %0d differing words, expected 0", t, bad);
            else passes++;
            if (t == 2) begin
                checks++;
                if (mem[6] !== 16'h0BEE || mem[7] !== 16'h0BEE || mem[8] !== 16'h0BEE)
                    $display("FAIL overlap_replicate: got %h %h %h, expected 0bee x3", mem[6], mem[7], mem[8]);
                else passes++;
            end
        end
        checks++;
        if (both_total != 0) $display("FAIL rd_wr_exclusive: got %0d overlapping cycles, expected 0", both_total);
        else passes++;
    endtask

    task automatic test_start_while_busy();
        int wb, db, bb, bad;
        model_op(1'b0, 16'h0100, 16'h0128, 7'd5, 16'h0);
        wb = wr_a_q.size(); db = done_total; bb = busy_total;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.src_addr = 16'h0100; bus.dst_addr = 16'h0128;
        bus.length = 7'd5; bus.fill_data = 16'h0;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b1; bus.src_addr = 16'h0; bus.dst_addr = 16'h0003;
        bus.length = 7'd20; bus.fill_data = 16'hDEAD;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (bus.done === 1'b1) break;
        end
        repeat (3) @(negedge clk); #1;
        checks++;
        if (done_total - db != 1) $display("FAIL busy_start_done: got %0d pulses, expected 1", done_total - db);
        else passes++;
        checks++;
        if (busy_total - bb != exp_lat) $display("FAIL busy_start_busy: got %0d, expected %0d", busy_total - bb, exp_lat);
        else passes++;
        bad = 0;
        if (wr_a_q.size() - wb != exp_wa.size()) bad = 99;
        else for (int i = 0; i < exp_wa.size(); i++)
            if (wr_a_q[wb + i] !== exp_wa[i] || wr_d_q[wb + i] !== exp_wd[i]) bad++;
        checks++;
        if (bad != 0) $display("FAIL busy_start_writes: got %0d bad writes, expected 0", bad);
        else passes++;
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) $display("FAIL busy_start_mem: got %0d differing words, expected 0", bad);
        else passes++;
    endtask

    task automatic test_async_reset();
        int wb, db, lat, bad;
        bit tmo;
        ref_mem[6'h38] = ref_mem[6'h30];
        wb = wr_a_q.size(); db = done_total;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.src_addr = 16'h0030; bus.dst_addr = 16'h0038;
        bus.length = 7'd3; bus.fill_data = 16'h0;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.mem_read !== 1'b1 || bus.address !== 16'h0031)
            $display("FAIL arst_pre_state: got rd=%b addr=%h, expected rd=1 addr=0031", bus.mem_read, bus.address);
        else passes++;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.address} !== 20'h0)
            $display("FAIL arst_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h, expected all 0",
                     bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.address);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk); #1;
        checks++;
        if (wr_a_q.size() - wb != 1 || wr_a_q[wb] !== 16'h0038)
            $display("FAIL arst_writes: got %0d writes, expected 1 to 0038", wr_a_q.size() - wb);
        else passes++;
        checks++;
        if (done_total != db) $display("FAIL arst_no_done: got %0d pulses, expected 0", done_total - db);
        else passes++;
        model_op(1'b0, 16'h0030, 16'h0039, 7'd4, 16'h0);
        db = done_total;
        do_op(1'b1, 1'b0, 16'h0030, 16'h0039, 7'd4, 16'h0, lat, tmo);
        repeat (2) @(negedge clk); #1;
        checks++;
        if (tmo || lat != exp_lat) $display("FAIL arst_recover_lat: got %0d, expected %0d", lat, exp_lat);
        else passes++;
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0 || done_total - db != 1)
            $display("FAIL arst_recover_mem: got %0d bad words %0d dones, expected 0 and 1", bad, done_total - db);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, db, wb, bad, n1;
        bit tmo1, tmo2;
        db = done_total; wb = wr_a_q.size();
        model_op(1'b1, 16'h0, 16'h0020, 7'd6, 16'h7E7E);
        n1 = exp_wa.size();
        do_op(1'b1, 1'b1, 16'h0, 16'h0020, 7'd6, 16'h7E7E, lat1, tmo1);
        model_op(1'b0, 16'h0020, 16'h0002, 7'd5, 16'h0);
        do_op(1'b0, 1'b0, 16'h0020, 16'h0002, 7'd5, 16'h0, lat2, tmo2);
        repeat (2) @(negedge clk); #1;
        checks++;
        if (tmo1 || tmo2 || lat2 != exp_lat)
            $display("FAIL b2b_latency: got %0d, expected %0d", lat2, exp_lat);
        else passes++;
        checks++;
        if (done_total - db != 2 || wr_a_q.size() - wb != n1 + exp_wa.size())
            $display("FAIL b2b_counts: got %0d dones %0d writes, expected 2 and %0d",
                     done_total - db, wr_a_q.size() - wb, n1 + exp_wa.size());
        else passes++;
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) $display("FAIL b2b_mem: got %0d differing words, expected 0", bad);
        else passes++;
    endtask

    initial begin
        tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
        bus.length = '0; bus.fill_data = '0;
        test_reset();
        test_transfers();
        test_start_while_busy();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
